// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit.
// Contents: size encodings, FSM state enum and the misalignment rule.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  // A reserved size is reported through the same error path as misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle for the load/store unit.
// Groups the pipeline request/response handshake and the word-wide data
// memory port. The master modport is the pipeline + memory side; the slave
// modport is the load/store unit itself.
interface mem_access_unit_if #(parameter int ADDR_W = 32);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_write_data;
  logic              dm_wr_en;
  logic              dm_rd_en;
  logic [31:0]       dm_read_data;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  dm_addr, dm_write_data, dm_wr_en, dm_rd_en,
    output dm_read_data
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dm_addr, dm_write_data, dm_wr_en, dm_rd_en,
    input  dm_read_data
  );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering for sub-word accesses (little-endian).
// Ports:
//   rd_word     in  word read from memory
//   size        in  access size encoding
//   offset      in  byte offset addr[1:0]
//   is_unsigned in  1 = zero-extend loads, 0 = sign-extend
//   old_word    in  word captured before a sub-word store
//   wdata       in  right-justified store data
//   load_val    out extracted and extended load value
//   merged_word out old_word with the addressed lane(s) replaced
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rd_word[{offset, 3'b000} +: 8];
  assign half_lane = rd_word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    load_val = rd_word;
    case (size)
      SZ_BYTE: load_val = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_val = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: load_val = rd_word;
    endcase
  end

  // Each byte lane independently decides whether it is overwritten and which
  // byte of the right-justified store data lands in it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       sel;
    logic [7:0] src;

    assign sel = (size == SZ_WORD) ||
                 ((size == SZ_HALF) && (offset[1] == LANE[1])) ||
                 ((size == SZ_BYTE) && (offset == LANE));

    always_comb begin
      src = wdata[8*gi +: 8];
      case (size)
        SZ_BYTE: src = wdata[7:0];
        SZ_HALF: src = wdata[8*(gi % 2) +: 8];
        default: src = wdata[8*gi +: 8];
      endcase
    end

    assign merged_word[8*gi +: 8] = sel ? src : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline MEM stage and a word-wide data memory.
// Adds byte/half loads with extension, byte/half stores via read-modify-write
// and misalignment detection, behind a valid/ready request and a one-cycle
// response pulse.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport: req_*/resp_* handshake and dm_* memory port
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rword_reg;
  logic [31:0]       rdata_reg;

  logic [31:0]       load_val;
  logic [31:0]       merged_word;
  logic              accept;

  assign accept = (state_reg == IDLE) && bus.req_valid;

  mem_lane_align u_align (
    .rd_word     (bus.dm_read_data),
    .size        (size_reg),
    .offset      (addr_reg[1:0]),
    .is_unsigned (uns_reg),
    .old_word    (rword_reg),
    .wdata       (wdata_reg),
    .load_val    (load_val),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rword_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg    <= bus.req_we;
        size_reg  <= bus.req_size;
        uns_reg   <= bus.req_unsigned;
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
        // Stores and errors report zero data, so clear any stale load result.
        rdata_reg <= '0;
      end
      if (state_reg == RD) begin
        rword_reg <= bus.dm_read_data;
        if (!we_reg) rdata_reg <= load_val;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (is_misaligned(bus.req_size, bus.req_addr[1:0])) state_next = RESP;
          else if (!bus.req_we)                               state_next = RD;
          else if (bus.req_size == SZ_WORD)                   state_next = WR;
          else                                                state_next = RD;
        end
      end
      // RD serves both loads and the read half of a sub-word store.
      RD:      state_next = we_reg ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs are pure state decodes so reset removes them at once.
  assign bus.req_ready     = (state_reg == IDLE);
  assign bus.dm_rd_en      = (state_reg == RD);
  assign bus.dm_wr_en      = (state_reg == WR);
  assign bus.resp_valid    = (state_reg == RESP);
  assign bus.resp_err      = (state_reg == RESP) && is_misaligned(size_reg, addr_reg[1:0]);
  assign bus.resp_rdata    = rdata_reg;
  assign bus.dm_addr       = {addr_reg[ADDR_W-1:2], 2'b00};
  // For word stores every lane is replaced, so this is simply wdata_reg.
  assign bus.dm_write_data = merged_word;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, reset-abort and
// back-to-back sequences, then random traffic against a byte-level model.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   acc_cnt;

  mem_access_unit_if #(.ADDR_W(32)) bus();

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, word write on the clock edge.
  logic [31:0] mem [0:4095] = '{default: 32'h0};
  assign bus.dm_read_data = mem[bus.dm_addr[13:2]];
  always @(posedge clk) begin
    if (bus.dm_wr_en) mem[bus.dm_addr[13:2]] <= bus.dm_write_data;
  end

  always @(posedge clk) begin
    if (!rst && bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
  end

  // Reference memory, handled as individual bytes.
  logic [31:0] ref_mem [0:63];

  function automatic logic [7:0] ref_byte(input int b);
    logic [31:0] w;
    w = ref_mem[(b / 4) % 64];
    return 8'((w >> (8 * (b % 4))) & 32'hFF);
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] addr);
    int nb;
    nb = 1 << sz;
    return (sz == 2'd3) || ((addr % nb) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    v = 32'h0;
    if (ref_err(sz, addr)) return 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_byte(int'(addr) + i)) << (8 * i));
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  function automatic int ref_lat(input logic we, input logic [1:0] sz, input logic [31:0] addr);
    if (ref_err(sz, addr)) return 1;
    if (!we || sz == 2'd2) return 2;
    return 3;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    int nb, b, idx, sh;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++) begin
      b   = int'(addr) + i;
      idx = (b / 4) % 64;
      sh  = 8 * (b % 4);
      ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | (((wd >> (8 * i)) & 32'hFF) << sh);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        timeout;
  } res_t;

  // Issue one request and observe it to completion; updates the model.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, output res_t r);
    int guard;
    r = '{32'h0, 1'b0, 0, 0, 0, 32'h0, 32'h0, 1'b0};
    @(negedge clk);
    bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    r.lat = 1;
    forever begin
      if (bus.dm_rd_en) r.rd++;
      if (bus.dm_wr_en) begin r.wr++; r.wr_addr = bus.dm_addr; r.wr_data = bus.dm_write_data; end
      if (bus.resp_valid || r.lat >= 10) break;
      @(negedge clk);
      r.lat++;
    end
    if (bus.resp_valid) begin
      r.rdata = bus.resp_rdata;
      r.err   = bus.resp_err;
    end else begin
      r.timeout = 1'b1;
    end
    if (we && !ref_err(sz, addr)) ref_store(sz, addr, wd);
    $display("[TB] txn we=%0d sz=%0d uns=%0d addr=%h wd=%h -> rdata=%h err=%0d lat=%0d",
             we, sz, uns, addr, wd, r.rdata, r.err, r.lat);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t tbl [13];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    res_t        r;
    logic [31:0] q_exp [$];
    logic [31:0] q_got [$];
    int          acc0, guard;
    logic        b_we, b_uns;
    logic [1:0]  b_sz;
    logic [31:0] b_addr, b_wd;

    tests = 0; failed = 0; acc_cnt = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h41, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 1, 0, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h41, 32'h0,        32'h000000BE, 1'b0, 2, 1, 0, 32'h0};
    tbl[3]  = '{1'b0, 2'd1, 1'b0, 32'h42, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 1, 0, 32'h0};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h43, 32'h12,       32'h0,        1'b0, 3, 1, 1, 32'h12ADBEEF};
    tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h12ADBEEF, 1'b0, 2, 1, 0, 32'h0};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h41, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h42, 32'h55555555, 32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h40, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0,        32'h12ADBEEF, 1'b0, 2, 1, 0, 32'h0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h46, 32'h0000A5A5, 32'h0,        1'b0, 3, 1, 1, 32'hA5A50000};
    tbl[11] = '{1'b0, 2'd1, 1'b1, 32'h46, 32'h0,        32'h0000A5A5, 1'b0, 2, 1, 0, 32'h0};
    tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h46, 32'h0,        32'hFFFFA5A5, 1'b0, 2, 1, 0, 32'h0};

    // Reset state.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'h1);
    chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("reset_resp_err", 32'(bus.resp_err), 32'h0);
    chk("reset_resp_rdata", bus.resp_rdata, 32'h0);
    chk("reset_dm_rd_en", 32'(bus.dm_rd_en), 32'h0);
    chk("reset_dm_wr_en", 32'(bus.dm_wr_en), 32'h0);
    chk("reset_dm_addr", bus.dm_addr, 32'h0);
    chk("reset_dm_write_data", bus.dm_write_data, 32'h0);

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      run_req(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd, r);
      chk($sformatf("tbl%0d_timeout", i), 32'(r.timeout), 32'h0);
      chk($sformatf("tbl%0d_rdata", i), r.rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), 32'(r.err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_latency", i), 32'(r.lat), 32'(tbl[i].exp_lat));
      chk($sformatf("tbl%0d_rd_cycles", i), 32'(r.rd), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_wr_cycles", i), 32'(r.wr), 32'(tbl[i].exp_wr));
      if (tbl[i].exp_wr == 1) begin
        chk($sformatf("tbl%0d_wr_data", i), r.wr_data, tbl[i].exp_wdata);
        chk($sformatf("tbl%0d_wr_addr", i), r.wr_addr, tbl[i].addr & 32'hFFFFFFFC);
      end
    end
    chk("tbl_mem_0x40", mem[16], 32'h12ADBEEF);

    // Reset asserted in the WR cycle of a byte store.
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h77; bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_wr_en_before_rst", 32'(bus.dm_wr_en), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("abort_wr_en_async_drop", 32'(bus.dm_wr_en), 32'h0);
    chk("abort_resp_valid_in_rst", 32'(bus.resp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready_after", 32'(bus.req_ready), 32'h1);
    guard = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) guard++;
    end
    chk("abort_no_resp", 32'(guard), 32'h0);
    chk("abort_mem_unchanged", mem[16], 32'h12ADBEEF);
    $display("[TB] txn reset-abort byte store at 00000040 done");

    // Three loads with req_valid held high throughout.
    acc0 = acc_cnt;
    q_exp.push_back(ref_load(2'd2, 1'b0, 32'h40));
    q_exp.push_back(ref_load(2'd1, 1'b1, 32'h46));
    q_exp.push_back(ref_load(2'd0, 1'b0, 32'h43));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.resp_valid) q_got.push_back(bus.resp_rdata);
      bus.req_we = 1'b0; bus.req_valid = 1'b1;
      bus.req_size = (i == 0) ? 2'd2 : (i == 1) ? 2'd1 : 2'd0;
      bus.req_unsigned = (i == 1);
      bus.req_addr = (i == 0) ? 32'h40 : (i == 1) ? 32'h46 : 32'h43;
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
        @(negedge clk);
        if (bus.resp_valid) q_got.push_back(bus.resp_rdata);
        guard++;
      end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    guard = 0;
    while (guard < 8) begin
      if (bus.resp_valid) q_got.push_back(bus.resp_rdata);
      @(negedge clk);
      guard++;
    end
    chk("b2b_accept_count", 32'(acc_cnt - acc0), 32'd3);
    chk("b2b_resp_count", 32'(q_got.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_rdata%0d", i), (i < q_got.size()) ? q_got[i] : 32'hXXXXXXXX, q_exp[i]);
      $display("[TB] txn b2b load %0d expected=%h", i, q_exp[i]);
    end

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] e_rdata;
      int          e_lat;
      logic        e_err;
      b_we   = 1'($urandom_range(0, 1));
      b_sz   = 2'($urandom_range(0, 3));
      b_uns  = 1'($urandom_range(0, 1));
      b_addr = 32'($urandom_range(0, 255));
      b_wd   = $urandom;
      e_err   = ref_err(b_sz, b_addr);
      e_lat   = ref_lat(b_we, b_sz, b_addr);
      e_rdata = b_we ? 32'h0 : ref_load(b_sz, b_uns, b_addr);
      run_req(b_we, b_sz, b_uns, b_addr, b_wd, r);
      chk($sformatf("rnd%0d_rdata", n), r.rdata, e_rdata);
      chk($sformatf("rnd%0d_err", n), 32'(r.err), 32'(e_err));
      chk($sformatf("rnd%0d_latency", n), 32'(r.lat), 32'(e_lat));
    end
    for (int i = 0; i < 64; i++) chk($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the pipeline MEM stage and the word-wide data memory, which offers combinational read, word-only writes and word address addr[13:2].
- Adds byte and halfword loads with sign or zero extension.
- Adds byte and halfword stores by read-modify-write, plus misalignment detection.
- Runs a valid/ready request with a one-cycle response pulse; the pipeline stalls while req_ready=0.

Parameters:
ADDR_W, 32, byte-address width on both the request and memory sides.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready at posedge.
req_we  in  1  1=store, 0=load.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend; ignored for stores.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-justified for byte/half.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  extended load data; valid while resp_valid; 0 for stores and errors.
resp_err  out  1  misaligned or reserved size; valid with resp_valid.
dm_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
dm_write_data  out  32  merged store word.
dm_wr_en  out  1  memory write enable.
dm_rd_en  out  1  memory read enable.
dm_read_data  in  32  combinational read data from memory.

Behaviour:
- Reset: state=IDLE; latched request fields, captured read word and resp_rdata cleared to 0. Outputs are decoded from state, so dm_wr_en, dm_rd_en, resp_valid and resp_err drop immediately on rst. An operation in flight is abandoned; a partial RMW never writes.
- Reset values: req_ready=1 after reset; all other outputs 0.
- Request latching: at acceptance, latch we, size, unsigned, addr and wdata into registers. From then on, only latched values drive the memory side.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Goes IDLE->RESP; dm_rd_en and dm_wr_en never assert; resp_err=1; resp_rdata=0.
- States: IDLE, RD, WR, RESP.
- Load path: IDLE->RD->RESP. In RD, dm_rd_en=1. At the RD->RESP edge, resp_rdata captures the lane-extracted, extended value.
- Word store path: IDLE->WR->RESP.
- Sub-word store path: IDLE->RD->WR->RESP. In RD, dm_read_data is captured. In WR, dm_write_data is the captured word with the selected lane(s) replaced.
- WR state: dm_wr_en=1 for exactly one full cycle, with dm_addr and dm_write_data stable the whole cycle, so writing on either clock edge is safe.
- RESP state: resp_valid=1 for exactly one cycle, then IDLE.
- Latency from the acceptance edge to resp_valid high:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Lane mapping (little-endian):
  - byte k occupies bits [8k+7:8k], k=addr[1:0].
  - halfword h occupies bits [16h+15:16h], h=addr[1].
- Extension: sign mode replicates the lane MSB into the upper bits; unsigned mode fills them with 0. Word loads pass through unchanged.
- Back-to-back: req_ready=0 in RD, WR and RESP; req_valid there is ignored and must be held by the requester. A new request is accepted at the earliest on the edge ending RESP+1, i.e. while in IDLE.
- Address: dm_addr always has bits [1:0]=00. The upper bits pass through unchanged; memory-side wrap via addr[13:2] is not this block's concern.

Decomposition:
- Package mips_mem_pkg: size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD; state enum (IDLE, RD, WR, RESP); function is_misaligned(size, addr_lo).
- One combinational sub-module, mem_lane_align, containing:
  - extract+extend: word, size, offset, unsigned -> 32-bit load value
  - merge: old word, wdata, size, offset -> new word
- The FSM and registers stay in mem_access_unit.

Test Plan:
1. Store word 0xDEADBEEF at 0x40 -> dm_wr_en high one cycle, dm_addr=0x40, dm_write_data=0xDEADBEEF, resp_valid 2 cycles after accept, resp_err=0, dm_rd_en never high.
2. Memory[0x40]=0xDEADBEEF; load byte signed at 0x41 -> resp_rdata=0xFFFFFFBE; same load unsigned -> 0x000000BE; load half signed at 0x42 -> 0xFFFFDEAD.
3. Store byte 0x12 at 0x43 over 0xDEADBEEF -> RD then WR, dm_write_data=0x12ADBEEF, resp_valid 3 cycles after accept; a following word load at 0x40 returns 0x12ADBEEF.
4. Load half at 0x41, store word at 0x42, and size=11 -> resp_err=1 one cycle after accept, resp_rdata=0, no dm_rd_en/dm_wr_en; memory unchanged.
5. Assert rst during WR of a byte store -> dm_wr_en falls without waiting for a clock edge, no resp_valid, req_ready=1 after release, target word unchanged.
6. req_valid held high continuously with 3 queued loads -> each accepted only in IDLE, exactly one resp_valid per request, in order, no request dropped or duplicated.
